// File: rtl/board_io_pkg.sv
// Shared types and constants for the board-level I/O controller.
//   led_mode_t  : LED display mode selected by the mode key
//   rst_state_t : core reset sequencer state
//   KEY_RESET   : index of the key that resets the core
//   KEY_MODE    : index of the key that steps the LED mode
package board_io_pkg;

    typedef enum logic [1:0] {
        LED_LOW       = 2'd0,
        LED_HIGH      = 2'd1,
        LED_HEARTBEAT = 2'd2,
        LED_STICKY    = 2'd3
    } led_mode_t;

    typedef enum logic {
        RST_HOLD = 1'b0,
        RST_RUN  = 1'b1
    } rst_state_t;

    localparam int KEY_RESET = 0;
    localparam int KEY_MODE  = 1;

    // Next LED mode in the cycle LOW -> HIGH -> HEARTBEAT -> STICKY -> LOW.
    function automatic led_mode_t next_mode(input led_mode_t mode);
        logic [1:0] raw;
        raw = mode;
        raw = raw + 2'd1;
        return led_mode_t'(raw);
    endfunction

endpackage

// File: rtl/board_io_ctrl_key_debounce.sv
// Synchroniser and debouncer for one active-low push-button.
//   clk, reset : system clock, asynchronous active-low reset
//   key_n      : raw asynchronous key level, 0 = pressed
//   stable     : debounced level, 1 = released
//   press      : one-cycle pulse the cycle after stable falls
module key_debounce
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic stable,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic          stable_d_r;
    logic [CW-1:0] cnt_r;
    logic          press_r;

    // Two-flop synchroniser; idles at the released level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_r <= 1'b1;
            cnt_r    <= {CW{1'b0}};
        end else if (sync2_r == stable_r) begin
            stable_r <= stable_r;
            cnt_r    <= {CW{1'b0}};
        end else if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable_r <= sync2_r;
            cnt_r    <= {CW{1'b0}};
        end else begin
            stable_r <= stable_r;
            cnt_r    <= cnt_r + CW'(1'b1);
        end
    end

    // Press pulse from the falling edge of the debounced level, one cycle late.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_d_r <= 1'b1;
            press_r    <= 1'b0;
        end else begin
            stable_d_r <= stable_r;
            press_r    <= stable_d_r & ~stable_r;
        end
    end

    assign stable = stable_r;
    assign press  = press_r;

endmodule

// File: rtl/board_io_ctrl.sv
// Board-level I/O controller: debounces the keys, sequences a stretched
// core reset and drives the LED bank from the core status word.
//   clk, reset   : system clock, asynchronous active-low reset
//   key_n_i      : raw active-low keys (key 0 resets core, key 1 steps mode)
//   status_i     : core status word shown on the LEDs
//   core_reset_o : registered active-low core reset
//   key_press_o  : one-cycle pulse per debounced press
//   mode_o       : current LED mode
//   led_o        : registered LED drive, 1 = lit
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int NUM_KEYS          = 4,
    parameter int NUM_LEDS          = 10,
    parameter int STATUS_WIDTH      = 32,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int RESET_HOLD_CYCLES = 8,
    parameter int HEARTBEAT_WIDTH   = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_KEYS-1:0]     key_n_i,
    input  logic [STATUS_WIDTH-1:0] status_i,
    output logic                    core_reset_o,
    output logic [NUM_KEYS-1:0]     key_press_o,
    output logic [1:0]              mode_o,
    output logic [NUM_LEDS-1:0]     led_o
);

    localparam int HC = $clog2(RESET_HOLD_CYCLES + 1);

    if (NUM_LEDS > STATUS_WIDTH) begin : g_width_check
        $fatal(1, "board_io_ctrl: NUM_LEDS must not exceed STATUS_WIDTH");
    end

    logic [NUM_KEYS-1:0]        stable_s;
    rst_state_t                 state_r;
    logic [HC-1:0]              hold_cnt_r;
    logic                       core_reset_r;
    led_mode_t                  mode_r;
    logic [HEARTBEAT_WIDTH-1:0] hb_r;
    logic [NUM_LEDS-1:0]        sticky_r;
    logic [NUM_LEDS-1:0]        led_r;
    logic [NUM_LEDS-1:0]        led_s;
    logic [NUM_LEDS+1:0]        hb_pad_s;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_keys
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk    (clk),
            .reset  (reset),
            .key_n  (key_n_i[i]),
            .stable (stable_s[i]),
            .press  (key_press_o[i])
        );
    end

    // Core reset sequencer; a held reset key wins over a finishing hold count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= RST_HOLD;
            hold_cnt_r   <= {HC{1'b0}};
            core_reset_r <= 1'b0;
        end else begin
            case (state_r)
                RST_HOLD: begin
                    if (!stable_s[KEY_RESET]) begin
                        state_r      <= RST_HOLD;
                        hold_cnt_r   <= {HC{1'b0}};
                        core_reset_r <= 1'b0;
                    end else if (hold_cnt_r == HC'(RESET_HOLD_CYCLES - 1)) begin
                        state_r      <= RST_RUN;
                        hold_cnt_r   <= {HC{1'b0}};
                        core_reset_r <= 1'b1;
                    end else begin
                        state_r      <= RST_HOLD;
                        hold_cnt_r   <= hold_cnt_r + HC'(1'b1);
                        core_reset_r <= 1'b0;
                    end
                end
                RST_RUN: begin
                    if (!stable_s[KEY_RESET]) begin
                        state_r      <= RST_HOLD;
                        hold_cnt_r   <= {HC{1'b0}};
                        core_reset_r <= 1'b0;
                    end else begin
                        state_r      <= RST_RUN;
                        hold_cnt_r   <= {HC{1'b0}};
                        core_reset_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= RST_HOLD;
                    hold_cnt_r   <= {HC{1'b0}};
                    core_reset_r <= 1'b0;
                end
            endcase
        end
    end

    // LED mode steps on mode-key presses only; core reset leaves it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_r <= LED_LOW;
        end else if (key_press_o[KEY_MODE]) begin
            mode_r <= next_mode(mode_r);
        end else begin
            mode_r <= mode_r;
        end
    end

    // Free-running heartbeat, independent of the core reset state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hb_r <= {HEARTBEAT_WIDTH{1'b0}};
        end else begin
            hb_r <= hb_r + HEARTBEAT_WIDTH'(1'b1);
        end
    end

    // Sticky capture of low status bits since the last core reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_r <= {NUM_LEDS{1'b0}};
        end else if (state_r == RST_RUN) begin
            sticky_r <= sticky_r | status_i[NUM_LEDS-1:0];
        end else begin
            sticky_r <= {NUM_LEDS{1'b0}};
        end
    end

    // LED source select; the heartbeat pattern is built wide so NUM_LEDS=1 works.
    always_comb begin
        hb_pad_s      = {(NUM_LEDS + 2){1'b0}};
        hb_pad_s[1:0] = {(state_r == RST_RUN), hb_r[HEARTBEAT_WIDTH-1]};
        led_s         = {NUM_LEDS{1'b0}};
        case (mode_r)
            LED_LOW:       led_s = status_i[NUM_LEDS-1:0];
            LED_HIGH:      led_s = status_i[STATUS_WIDTH-1 -: NUM_LEDS];
            LED_HEARTBEAT: led_s = hb_pad_s[NUM_LEDS-1:0];
            LED_STICKY:    led_s = sticky_r;
            default:       led_s = {NUM_LEDS{1'b0}};
        endcase
    end

    // Registered LED drive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_r <= {NUM_LEDS{1'b0}};
        end else begin
            led_r <= led_s;
        end
    end

    assign core_reset_o = core_reset_r;
    assign mode_o       = mode_r;
    assign led_o        = led_r;

endmodule

// File: tb/tb_board_io_ctrl.sv
module tb_board_io_ctrl;

    localparam int NK = 4;
    localparam int NL = 10;
    localparam int SW = 32;

    logic          clk;
    logic          reset;
    logic [NK-1:0] key_n_i;
    logic [SW-1:0] status_i;
    logic          core_reset_o;
    logic [NK-1:0] key_press_o;
    logic [1:0]    mode_o;
    logic [NL-1:0] led_o;

    int errors = 0;
    int checks = 0;

    board_io_ctrl #(
        .NUM_KEYS(NK), .NUM_LEDS(NL), .STATUS_WIDTH(SW),
        .DEBOUNCE_CYCLES(4), .RESET_HOLD_CYCLES(8), .HEARTBEAT_WIDTH(4)
    ) dut (
        .clk(clk), .reset(reset), .key_n_i(key_n_i), .status_i(status_i),
        .core_reset_o(core_reset_o), .key_press_o(key_press_o),
        .mode_o(mode_o), .led_o(led_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_key(input int idx, input int hold, input int settle);
        key_n_i[idx] = 1'b0;
        ticks(hold);
        key_n_i[idx] = 1'b1;
        ticks(settle);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        key_n_i = '1;
        status_i = 32'h0000_03FF;
        for (int n = 1; n <= 10; n++) begin
            tick();
            checks++;
            if (led_o !== 10'h000 || core_reset_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold n=%0d: led=%h core_reset=%b required led=000 core_reset=0", n, led_o, core_reset_o);
            end
        end
        checks++;
        if (mode_o !== 2'd0 || key_press_o !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mode: mode=%0d press=%b required 0 and 0000", mode_o, key_press_o);
        end
        status_i = '0;
        reset = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            tick();
            checks++;
            if (core_reset_o !== (n >= 8)) begin
                errors++;
                $display("FAIL poweron_seq n=%0d: core_reset=%b required %b", n, core_reset_o, (n >= 8));
            end
        end
    endtask

    task automatic test_debounce();
        key_n_i[1] = 1'b0;
        ticks(3);
        key_n_i[1] = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            checks++;
            if (key_press_o !== 4'b0000) begin
                errors++;
                $display("FAIL glitch_press n=%0d: press=%b required 0000", n, key_press_o);
            end
        end
        checks++;
        if (mode_o !== 2'd0) begin
            errors++;
            $display("FAIL glitch_mode: mode=%0d required 0", mode_o);
        end
        key_n_i[1] = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            checks++;
            if (key_press_o !== ((n == 7) ? 4'b0010 : 4'b0000)) begin
                errors++;
                $display("FAIL press_pulse n=%0d: press=%b required %b", n, key_press_o, ((n == 7) ? 4'b0010 : 4'b0000));
            end
        end
        key_n_i[1] = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            checks++;
            if (key_press_o !== 4'b0000) begin
                errors++;
                $display("FAIL release_press n=%0d: press=%b required 0000", n, key_press_o);
            end
        end
        checks++;
        if (mode_o !== 2'd1) begin
            errors++;
            $display("FAIL press_mode: mode=%0d required 1", mode_o);
        end
    endtask

    task automatic test_mode_mux();
        int t0;
        int t1;
        int ntr;
        logic prev;
        status_i = 32'hA5A5_0F3C;
        ticks(2);
        checks++;
        if (led_o !== 10'h296) begin
            errors++;
            $display("FAIL led_high: led=%h required 296", led_o);
        end
        press_key(1, 10, 10);
        checks++;
        if (mode_o !== 2'd2 || led_o[9:1] !== 9'b000000001) begin
            errors++;
            $display("FAIL led_heartbeat: mode=%0d led=%b required mode 2 led 000000001x", mode_o, led_o);
        end
        ntr = 0;
        t0 = -1;
        t1 = -1;
        prev = led_o[0];
        for (int n = 1; n <= 16; n++) begin
            tick();
            if (led_o[0] !== prev) begin
                ntr++;
                if (t0 < 0) t0 = n;
                else t1 = n;
            end
            prev = led_o[0];
        end
        checks++;
        if (ntr !== 2 || (t1 - t0) !== 8) begin
            errors++;
            $display("FAIL hb_toggle: transitions=%0d spacing=%0d required 2 and 8", ntr, t1 - t0);
        end
        press_key(1, 10, 10);
        checks++;
        if (mode_o !== 2'd3 || led_o !== 10'h33C) begin
            errors++;
            $display("FAIL led_sticky_entry: mode=%0d led=%h required 3 and 33c", mode_o, led_o);
        end
    endtask

    task automatic test_sticky();
        status_i = '0;
        key_n_i[0] = 1'b0;
        ticks(10);
        key_n_i[0] = 1'b1;
        ticks(2);
        checks++;
        if (core_reset_o !== 1'b0 || led_o !== 10'h000) begin
            errors++;
            $display("FAIL sticky_clear: core_reset=%b led=%h required 0 and 000", core_reset_o, led_o);
        end
        ticks(14);
        checks++;
        if (core_reset_o !== 1'b1 || led_o !== 10'h000) begin
            errors++;
            $display("FAIL sticky_run: core_reset=%b led=%h required 1 and 000", core_reset_o, led_o);
        end
        status_i = 32'h0000_0001;
        tick();
        status_i = '0;
        tick();
        status_i = 32'h0000_0200;
        tick();
        status_i = '0;
        ticks(3);
        checks++;
        if (led_o !== 10'h201) begin
            errors++;
            $display("FAIL sticky_capture: led=%h required 201", led_o);
        end
        ticks(5);
        checks++;
        if (led_o !== 10'h201) begin
            errors++;
            $display("FAIL sticky_hold: led=%h required 201", led_o);
        end
    endtask

    task automatic test_key0_reset();
        key_n_i[0] = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            checks++;
            if (core_reset_o !== (n < 7)) begin
                errors++;
                $display("FAIL key0_press n=%0d: core_reset=%b required %b", n, core_reset_o, (n < 7));
            end
        end
        key_n_i[0] = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            checks++;
            if (core_reset_o !== (n >= 14)) begin
                errors++;
                $display("FAIL key0_release n=%0d: core_reset=%b required %b", n, core_reset_o, (n >= 14));
            end
        end
        checks++;
        if (mode_o !== 2'd3) begin
            errors++;
            $display("FAIL key0_mode: mode=%0d required 3", mode_o);
        end
    endtask

    task automatic test_both_keys();
        status_i = 32'hA5A5_0F3C;
        key_n_i[1:0] = 2'b00;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (n == 7) begin
                checks++;
                if (key_press_o !== 4'b0011) begin
                    errors++;
                    $display("FAIL both_pulse: press=%b required 0011", key_press_o);
                end
            end
        end
        checks++;
        if (mode_o !== 2'd0 || core_reset_o !== 1'b0) begin
            errors++;
            $display("FAIL both_effect: mode=%0d core_reset=%b required 0 and 0", mode_o, core_reset_o);
        end
        ticks(2);
        key_n_i[1:0] = 2'b11;
        ticks(16);
        checks++;
        if (core_reset_o !== 1'b1 || led_o !== 10'h33C) begin
            errors++;
            $display("FAIL both_recover: core_reset=%b led=%h required 1 and 33c", core_reset_o, led_o);
        end
    endtask

    task automatic test_async_reset();
        press_key(1, 10, 10);
        checks++;
        if (mode_o !== 2'd1) begin
            errors++;
            $display("FAIL async_premode: mode=%0d required 1", mode_o);
        end
        key_n_i[0] = 1'b0;
        ticks(10);
        key_n_i[0] = 1'b1;
        ticks(11);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (core_reset_o !== 1'b0 || mode_o !== 2'd0 || led_o !== 10'h000) begin
            errors++;
            $display("FAIL async_hold: core_reset=%b mode=%0d led=%h required 0 0 000", core_reset_o, mode_o, led_o);
        end
        ticks(2);
        reset = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            tick();
            checks++;
            if (core_reset_o !== (n >= 8)) begin
                errors++;
                $display("FAIL async_rehold n=%0d: core_reset=%b required %b", n, core_reset_o, (n >= 8));
            end
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (core_reset_o !== 1'b0) begin
            errors++;
            $display("FAIL async_run: core_reset=%b required 0", core_reset_o);
        end
        ticks(2);
        reset = 1'b1;
        ticks(2);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_mode_mux();
        test_sticky();
        test_key0_reset();
        test_both_keys();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
